// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: BCD time-of-day counter with two-button set mode and blinking field display
module clock_time_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [23:0] digit_data,
  output logic [5:0]  digit_en,
  output logic        sec_tick,
  output logic [1:0]  mode
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW = $clog2(CLK_HZ);
  localparam int BW = $clog2(HALF + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(HALF - 1);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] bl_q, bl_d;
  logic ph_q, ph_d, tick, inc, clr, tick_q;
  logic [7:0] hr_q, mn_q, sc_q, hr_d, mn_d, sc_d;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    return v == last ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  // next state, time fields, prescaler and blink timer; key_mode takes priority over key_inc
  always_comb begin
    tick = state_q == RUN && pre_q == PRE_LAST;
    inc = key_inc && !key_mode;
    state_d = !key_mode ? state_q : state_q == RUN ? SET_HR : state_q == SET_HR ? SET_MIN : RUN;
    sc_d = (key_mode && state_q == RUN) ? 8'h00 : tick ? bcd_inc(sc_q, 8'h59) : sc_q;
    mn_d = ((tick && sc_q == 8'h59) || (inc && state_q == SET_MIN)) ? bcd_inc(mn_q, 8'h59) : mn_q;
    hr_d = ((tick && sc_q == 8'h59 && mn_q == 8'h59) || (inc && state_q == SET_HR)) ? bcd_inc(hr_q, 8'h23) : hr_q;
    pre_d = (state_q != RUN || state_d != RUN || tick) ? '0 : pre_q + PW'(1);
    clr = state_d == RUN || key_mode || inc;
    bl_d = (clr || bl_q == BL_LAST) ? '0 : bl_q + BW'(1);
    ph_d = !clr && (bl_q == BL_LAST ? !ph_q : ph_q);
  end
  // state registers with asynchronous reset to 00:00:00 in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pre_q <= '0;
      bl_q <= '0;
      ph_q <= 1'b0;
      tick_q <= 1'b0;
      hr_q <= 8'h00;
      mn_q <= 8'h00;
      sc_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      bl_q <= bl_d;
      ph_q <= ph_d;
      tick_q <= tick;
      hr_q <= hr_d;
      mn_q <= mn_d;
      sc_q <= sc_d;
    end
  end
  assign digit_data = {hr_q, mn_q, sc_q};
  assign digit_en = {state_q == SET_HR ? {2{~ph_q}} : 2'b11, state_q == SET_MIN ? {2{~ph_q}} : 2'b11, 2'b11};
  assign sec_tick = tick_q;
  assign mode = state_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: randomized and directed checks against a seconds-of-day reference model
module tb_clock_time_ctrl;
  localparam int CLK_HZ = 10;
  localparam int BLINK_HZ = 1;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  logic clk = 1'b0, rst_n = 1'b0, key_mode = 1'b0, key_inc = 1'b0;
  logic [23:0] digit_data;
  logic [5:0] digit_en;
  logic sec_tick;
  logic [1:0] mode;
  int n_chk = 0, n_pass = 0;
  int m_mode, m_pre, m_tod, m_bl;
  bit m_ph, m_tick;
  clock_time_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc),
    .digit_data(digit_data), .digit_en(digit_en), .sec_tick(sec_tick), .mode(mode)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [23:0] exp_data();
    int h, mi, s;
    h = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s = m_tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [5:0] exp_en();
    logic [5:0] e;
    e = 6'h3F;
    if (m_mode == 1 && m_ph) e[5:4] = 2'b00;
    if (m_mode == 2 && m_ph) e[3:2] = 2'b00;
    return e;
  endfunction
  task automatic check_all();
    check("data", 32'(digit_data), 32'(exp_data()));
    check("en", 32'(digit_en), 32'(exp_en()));
    check("tick", 32'(sec_tick), 32'(m_tick));
    check("mode", 32'(mode), 32'(m_mode));
  endtask
  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_tod = 0; m_bl = 0; m_ph = 0; m_tick = 0;
  endtask
  task automatic model_step(input bit km, input bit ki);
    int h, mi, s, nm;
    bit tk;
    h = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s = m_tod % 60;
    tk = m_mode == 0 && m_pre == CLK_HZ - 1;
    nm = km ? (m_mode + 1) % 3 : m_mode;
    if (tk) m_tod = (m_tod + 1) % 86400;
    if (km && m_mode == 0) m_tod = m_tod - m_tod % 60;
    else if (ki && !km && m_mode == 1) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
    else if (ki && !km && m_mode == 2) m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
    m_pre = (m_mode == 0 && nm == 0 && !tk) ? m_pre + 1 : 0;
    if (nm == 0 || km || ki) begin
      m_bl = 0; m_ph = 0;
    end else if (m_bl == HALF - 1) begin
      m_bl = 0; m_ph = !m_ph;
    end else m_bl++;
    m_tick = tk;
    m_mode = nm;
  endtask
  task automatic cyc(input bit km, input bit ki);
    key_mode = km;
    key_inc = ki;
    @(posedge clk);
    model_step(km, ki);
    #1 key_mode = 1'b0;
    key_inc = 1'b0;
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0);
      if (i % 10 == 0) check("tick_at_10s", 32'(sec_tick), 32'd1);
    end
    check("run_3s", 32'(digit_data), 32'h000003);
    cyc(1, 0);
    repeat (23) cyc(0, 1);
    cyc(1, 0);
    repeat (59) cyc(0, 1);
    cyc(1, 0);
    repeat (590) cyc(0, 0);
    check("pre_wrap", 32'(digit_data), 32'h235959);
    repeat (10) cyc(0, 0);
    check("wrap", 32'(digit_data), 32'h000000);
    cyc(1, 0);
    for (int i = 1; i <= 25; i++) begin
      cyc(0, 1);
      if (i == 23) check("hr_23", 32'(digit_data[23:16]), 32'h23);
      if (i == 24) check("hr_00", 32'(digit_data[23:16]), 32'h00);
      repeat (7) cyc(0, 0);
    end
    check("hr_01", 32'(digit_data), 32'h010000);
    cyc(1, 0);
    repeat (59) cyc(0, 1);
    check("min_59", 32'(digit_data), 32'h015900);
    cyc(0, 1);
    check("min_wrap", 32'(digit_data), 32'h010000);
    cyc(1, 0);
    check("back_run", 32'(mode), 32'd0);
    repeat (9) cyc(0, 0);
    check("no_early_tick", 32'(sec_tick), 32'd0);
    cyc(0, 0);
    check("tick_10", 32'(sec_tick), 32'd1);
    cyc(1, 1);
    check("mode_wins", 32'(digit_data[23:16]), 32'h01);
    do_reset();
    repeat (599) cyc(0, 0);
    cyc(1, 0);
    check("tick_vs_mode", 32'(digit_data), 32'h000100);
    check("tick_vs_mode_m", 32'(mode), 32'd1);
    cyc(1, 0);
    repeat (13) cyc(0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    check("arst_en", 32'(digit_en), 32'h3F);
    @(negedge clk) rst_n = 1'b1;
    repeat (3000) cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
